// File: rtl/aes_add_round_key_stream_if.sv
// Lane-serial AddRoundKey stream bundle: round-key offer, state lanes in, result lanes out.
// master drives the key/state and accepts results; slave is the AddRoundKey unit.
interface aes_add_round_key_stream_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned LANE_W = 8
);
  logic              key_valid;
  logic              key_ready;
  logic [DATA_W-1:0] key_in;
  logic              in_valid;
  logic              in_ready;
  logic [LANE_W-1:0] in_data;
  logic [LANE_W-1:0] in_mask;
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_data;
  logic              out_last;

  modport master (
    output key_valid, key_in, in_valid, in_data, in_mask, out_ready,
    input  key_ready, in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  key_valid, key_in, in_valid, in_data, in_mask, out_ready,
    output key_ready, in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/aes_add_round_key_stream.sv
// Lane-serial AES AddRoundKey: XORs each state lane with its round-key slice (and optional mask)
// into a single registered output stage with pass-through backpressure.
module aes_add_round_key_stream #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned LANE_W = 8,
  parameter bit          MASKED = 1'b0
) (
  input logic                       clk,
  input logic                       rst_n,
  aes_add_round_key_stream_if.slave bus_io
);
  localparam int unsigned BEATS = DATA_W / LANE_W;
  localparam int unsigned CntW  = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CntW-1:0]   beat_q, beat_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [LANE_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  logic              in_fire, out_fire, key_fire, is_last;
  logic [DATA_W-1:0] key_sel;
  logic [LANE_W-1:0] key_slice, mask_lane;

  assign bus_io.in_ready  = !out_valid_q || bus_io.out_ready;
  assign bus_io.key_ready = (beat_q == '0);
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_data  = out_data_q;
  assign bus_io.out_last  = out_last_q;

  assign in_fire  = bus_io.in_valid && bus_io.in_ready;
  assign out_fire = out_valid_q && bus_io.out_ready;
  assign key_fire = bus_io.key_valid && bus_io.key_ready;
  assign is_last  = (beat_q == CntW'(BEATS - 1));

  // key_fire only happens at beat 0, so this bypass covers exactly the first lane of a new key.
  assign key_sel = key_fire ? bus_io.key_in : key_q;

  if (MASKED) begin : gen_mask
    assign mask_lane = bus_io.in_mask;
  end else begin : gen_no_mask
    assign mask_lane = '0;
  end

  always_comb begin
    key_slice = '0;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (beat_q == CntW'(b)) begin
        key_slice = key_sel[DATA_W-1-b*LANE_W -: LANE_W];
      end
    end
  end

  always_comb begin
    beat_d      = beat_q;
    key_d       = key_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (key_fire) begin
      key_d = bus_io.key_in;
    end
    if (in_fire) begin
      out_data_d  = bus_io.in_data ^ key_slice ^ mask_lane;
      out_valid_d = 1'b1;
      out_last_d  = is_last;
      beat_d      = is_last ? '0 : beat_q + 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q      <= '0;
      key_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      beat_q      <= beat_d;
      key_q       <= key_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end
endmodule

// File: tb/tb_aes_add_round_key_stream.sv
// Scoreboard bench for aes_add_round_key_stream: 32-bit lanes (plain and masked), 8-bit lanes
// with output backpressure, and the single-beat 128-bit configuration.
module tb_aes_add_round_key_stream;
  typedef logic [128:0] w_t;

  localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KFF  = {16{8'hff}};
  localparam logic [127:0] KA5  = {16{8'ha5}};
  localparam logic [127:0] ST   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [31:0]  MASK = 32'h5a5a5a5a;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  aes_add_round_key_stream_if #(.DATA_W(128), .LANE_W(32))  if32 ();
  aes_add_round_key_stream_if #(.DATA_W(128), .LANE_W(32))  ifm ();
  aes_add_round_key_stream_if #(.DATA_W(128), .LANE_W(8))   if8 ();
  aes_add_round_key_stream_if #(.DATA_W(128), .LANE_W(128)) if128 ();

  aes_add_round_key_stream #(.DATA_W(128), .LANE_W(32), .MASKED(1'b0)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .bus_io(if32));
  aes_add_round_key_stream #(.DATA_W(128), .LANE_W(32), .MASKED(1'b1)) u_dutm (
    .clk(clk), .rst_n(rst_n), .bus_io(ifm));
  aes_add_round_key_stream #(.DATA_W(128), .LANE_W(8), .MASKED(1'b0)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus_io(if8));
  aes_add_round_key_stream #(.DATA_W(128), .LANE_W(128), .MASKED(1'b0)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .bus_io(if128));

  // The masked instance mirrors the 32-bit stimulus; its results differ only by the mask.
  assign ifm.key_valid = if32.key_valid;
  assign ifm.key_in    = if32.key_in;
  assign ifm.in_valid  = if32.in_valid;
  assign ifm.in_data   = if32.in_data;
  assign ifm.in_mask   = if32.in_mask;
  assign ifm.out_ready = if32.out_ready;

  w_t q32[$];
  w_t qm[$];
  w_t q8[$];
  w_t q128[$];

  task automatic check_eq(input string tag, input w_t obs, input w_t exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Output monitors: a beat is consumed on a negedge where valid & ready are both high.
  w_t e32, em, e8, e128;
  always @(negedge clk) begin
    if (rst_n && if32.out_valid && if32.out_ready) begin
      e32 = 'x;
      if (q32.size() != 0) e32 = q32.pop_front();
      check_eq("out32", {if32.out_last, 128'(if32.out_data)}, e32);
    end
    if (rst_n && ifm.out_valid && ifm.out_ready) begin
      em = 'x;
      if (qm.size() != 0) em = qm.pop_front();
      check_eq("outm", {ifm.out_last, 128'(ifm.out_data)}, em);
    end
    if (rst_n && if128.out_valid && if128.out_ready) begin
      e128 = 'x;
      if (q128.size() != 0) e128 = q128.pop_front();
      check_eq("out128", {if128.out_last, if128.out_data}, e128);
    end
  end

  logic       stall8_q = 1'b0;
  logic [8:0] hold8_q  = '0;
  always @(negedge clk) begin
    if (rst_n && if8.out_valid) begin
      if (stall8_q) check_eq("hold8", w_t'({if8.out_last, if8.out_data}), w_t'(hold8_q));
      if (!if8.out_ready) check_eq("inrdy8", w_t'(if8.in_ready), w_t'(1'b0));
      if (if8.out_ready) begin
        e8 = 'x;
        if (q8.size() != 0) e8 = q8.pop_front();
        check_eq("out8", {if8.out_last, 128'(if8.out_data)}, e8);
      end
      stall8_q <= !if8.out_ready;
      hold8_q  <= {if8.out_last, if8.out_data};
    end else begin
      stall8_q <= 1'b0;
    end
  end

  // 8-bit output backpressure pattern 1,0,0,1 while tog8 is set.
  logic       tog8 = 1'b0;
  logic [3:0] pat8 = 4'b1001;
  int         idx8 = 0;
  initial begin
    if8.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tog8) begin
        if8.out_ready = pat8[idx8];
        idx8 = (idx8 + 1) % 4;
      end else begin
        if8.out_ready = 1'b1;
        idx8 = 0;
      end
    end
  end

  task automatic send32(input logic [31:0] d, input logic [31:0] exp, input logic last,
                        input logic kv, input logic [127:0] k);
    logic fired = 1'b0;
    q32.push_back({last, 128'(exp)});
    qm.push_back({last, 128'(exp ^ MASK)});
    if32.in_valid = 1'b1;
    if32.in_data  = d;
    if (kv) begin
      if32.key_valid = 1'b1;
      if32.key_in    = k;
    end
    for (int n = 0; n < 40 && !fired; n++) begin
      @(negedge clk); fired = if32.in_ready;
      @(posedge clk); #1;
    end
    if32.in_valid = 1'b0;
    if (kv) if32.key_valid = 1'b0;
    check_eq("fire32", w_t'(fired), w_t'(1'b1));
    check_eq("lat32", w_t'({if32.out_valid, if32.out_last, if32.out_data}),
             w_t'({1'b1, last, exp}));
    check_eq("latm", w_t'({ifm.out_valid, ifm.out_last, ifm.out_data}),
             w_t'({1'b1, last, exp ^ MASK}));
  endtask

  task automatic send8(input logic [7:0] d, input logic [7:0] exp, input logic last);
    logic fired = 1'b0;
    q8.push_back({last, 128'(exp)});
    if8.in_valid = 1'b1;
    if8.in_data  = d;
    for (int n = 0; n < 40 && !fired; n++) begin
      @(negedge clk); fired = if8.in_ready;
      @(posedge clk); #1;
    end
    if8.in_valid = 1'b0;
    check_eq("fire8", w_t'(fired), w_t'(1'b1));
  endtask

  task automatic send128(input logic [127:0] d, input logic [127:0] exp,
                         input logic kv, input logic [127:0] k);
    logic fired = 1'b0;
    q128.push_back({1'b1, exp});
    if128.in_valid = 1'b1;
    if128.in_data  = d;
    if (kv) begin
      if128.key_valid = 1'b1;
      if128.key_in    = k;
    end
    for (int n = 0; n < 40 && !fired; n++) begin
      @(negedge clk); fired = if128.in_ready;
      @(posedge clk); #1;
    end
    if128.in_valid = 1'b0;
    if (kv) if128.key_valid = 1'b0;
    check_eq("fire128", w_t'(fired), w_t'(1'b1));
  endtask

  task automatic load_key32(input logic [127:0] k);
    logic ok = 1'b0;
    if32.key_valid = 1'b1;
    if32.key_in    = k;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk); ok = if32.key_ready;
      @(posedge clk); #1;
    end
    if32.key_valid = 1'b0;
    check_eq("key32", w_t'(ok), w_t'(1'b1));
  endtask

  task automatic load_key8(input logic [127:0] k);
    logic ok = 1'b0;
    if8.key_valid = 1'b1;
    if8.key_in    = k;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk); ok = if8.key_ready;
      @(posedge clk); #1;
    end
    if8.key_valid = 1'b0;
    check_eq("key8", w_t'(ok), w_t'(1'b1));
  endtask

  logic [31:0] st32 [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};

  initial begin
    rst_n = 1'b0;
    if32.key_valid = 1'b0; if32.key_in = '0; if32.in_valid = 1'b0; if32.in_data = '0;
    if32.in_mask = MASK; if32.out_ready = 1'b1;
    if8.key_valid = 1'b0; if8.key_in = '0; if8.in_valid = 1'b0; if8.in_data = '0;
    if8.in_mask = '0;
    if128.key_valid = 1'b0; if128.key_in = '0; if128.in_valid = 1'b0; if128.in_data = '0;
    if128.in_mask = '0; if128.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst32", w_t'({if32.out_valid, if32.out_last, if32.key_ready, if32.out_data}),
             w_t'({3'b001, 32'h0}));
    check_eq("rstm", w_t'({ifm.out_valid, ifm.out_last, ifm.key_ready, ifm.out_data}),
             w_t'({3'b001, 32'h0}));
    check_eq("rst8", w_t'({if8.out_valid, if8.out_last, if8.key_ready, if8.out_data}),
             w_t'({3'b001, 8'h0}));
    check_eq("rst128", {if128.out_valid, if128.out_data}, w_t'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 round 0 on 32-bit lanes; the masked twin sees the same lanes plus 5a5a5a5a.
    load_key32(K0);
    send32(st32[0], 32'h00102030, 1'b0, 1'b0, '0);
    send32(st32[1], 32'h40506070, 1'b0, 1'b0, '0);
    send32(st32[2], 32'h8090a0b0, 1'b0, 1'b0, '0);
    send32(st32[3], 32'hc0d0e0f0, 1'b1, 1'b0, '0);

    // Key offered mid-block must wait for the block boundary and not be lost.
    send32(st32[0], 32'h00102030, 1'b0, 1'b0, '0);
    send32(st32[1], 32'h40506070, 1'b0, 1'b0, '0);
    if32.key_valid = 1'b1;
    if32.key_in    = KFF;
    check_eq("krdy_b2", w_t'(if32.key_ready), w_t'(1'b0));
    send32(st32[2], 32'h8090a0b0, 1'b0, 1'b0, '0);
    check_eq("krdy_b3", w_t'(if32.key_ready), w_t'(1'b0));
    send32(st32[3], 32'hc0d0e0f0, 1'b1, 1'b0, '0);
    check_eq("krdy_end", w_t'(if32.key_ready), w_t'(1'b1));
    @(posedge clk); #1;
    if32.key_valid = 1'b0;
    send32(st32[0], 32'hffeeddcc, 1'b0, 1'b0, '0);
    for (int b = 1; b < 4; b++) send32(st32[b], ~st32[b], b == 3, 1'b0, '0);

    // Key and first lane accepted together: the new key must be used for beat 0.
    send32(st32[0], 32'ha5b48796, 1'b0, 1'b1, KA5);
    for (int b = 1; b < 4; b++) send32(st32[b], st32[b] ^ 32'ha5a5a5a5, b == 3, 1'b0, '0);

    // 8-bit lanes with output stalls.
    load_key8(K0);
    tog8 = 1'b1;
    for (int i = 0; i < 16; i++) send8(8'(i * 17), 8'(i * 16), i == 15);
    for (int n = 0; n < 60 && q8.size() != 0; n++) @(posedge clk);
    tog8 = 1'b0;
    #1;

    // Single-beat configuration: key_ready always high, every beat is last.
    check_eq("krdy128a", w_t'(if128.key_ready), w_t'(1'b1));
    send128(ST, 128'h00102030405060708090a0b0c0d0e0f0, 1'b1, K0);
    check_eq("krdy128b", w_t'(if128.key_ready), w_t'(1'b1));
    send128(ST, ST ^ KA5, 1'b1, KA5);
    check_eq("krdy128c", w_t'(if128.key_ready), w_t'(1'b1));

    // Reset partway through a block.
    send32(st32[0], st32[0] ^ 32'ha5a5a5a5, 1'b0, 1'b0, '0);
    send32(st32[1], st32[1] ^ 32'ha5a5a5a5, 1'b0, 1'b0, '0);
    send32(st32[2], st32[2] ^ 32'ha5a5a5a5, 1'b0, 1'b0, '0);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst32", w_t'({if32.out_valid, if32.out_data}), w_t'(0));
    check_eq("arstm", w_t'({ifm.out_valid, ifm.out_data}), w_t'(0));
    q32.delete();
    qm.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("krdy_rst", w_t'(if32.key_ready), w_t'(1'b1));
    send32(st32[0], st32[0], 1'b0, 1'b0, '0);
    send32(st32[1], st32[1], 1'b0, 1'b0, '0);

    for (int n = 0; n < 20 && (q32.size() + qm.size() + q8.size() + q128.size()) != 0; n++)
      @(posedge clk);
    #1;
    check_eq("drain32", w_t'(q32.size()), w_t'(0));
    check_eq("drainm", w_t'(qm.size()), w_t'(0));
    check_eq("drain8", w_t'(q8.size()), w_t'(0));
    check_eq("drain128", w_t'(q128.size()), w_t'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
